// File: rtl/reg_arb_pkg.sv
// Shared parameters, requester ids and writeback request type for the register-file write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package reg_arb_pkg;

    localparam int N_REQ_DEF  = 3;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    // Fixed requester slots on the writeback side
    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority arbiter: first asserted req scanning ptr, ptr+1, ... wrapping at N-1.
// Latency: purely combinational, zero cycles.
// Backpressure: none here; the caller masks the grant when it cannot accept.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    // Walk the requesters starting at ptr and grant the first one found
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!gnt_vld && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin share of the register-file write port among N_REQ writeback sources.
// Latency: one cycle from accept (Valid & Ready) to Write_Reg/Wr_Addr/Wr_Data; one write per cycle.
// Backpressure: Req_Ready is a one-hot grant, forced low by Stall or reset; losers hold their request.
// Build option: REG_WRITE_ARB_ZERO_FILTER_EN suppresses the write enable for accepted address-0 requests.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [N_REQ-1:0]        Req_Valid,
    input  logic [N_REQ*ADDR_W-1:0] Req_Addr,
    input  logic [N_REQ*DATA_W-1:0] Req_Data,
    output logic [N_REQ-1:0]        Req_Ready,
    input  logic                    Stall,
    output logic [ADDR_W-1:0]       Wr_Addr,
    output logic [DATA_W-1:0]       Wr_Data,
    output logic                    Write_Reg,
    output logic                    Busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              wr_vld_q, wr_vld_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic [N_REQ-1:0]  gnt;
    logic [PTR_W-1:0]  gnt_idx;
    logic              gnt_vld;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req     (Req_Valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Grant is only exposed when the port can take a write this cycle
    always_comb begin
        accept    = gnt_vld && !Stall && RST_N;
        Req_Ready = accept ? gnt : '0;
        sel_addr  = Req_Addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
        sel_data  = Req_Data[int'(gnt_idx)*DATA_W +: DATA_W];
    end

    // Next-state: register the winner, advance the pointer past it, hold data when idle
    always_comb begin
        ptr_d     = ptr_q;
        wr_vld_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (accept) begin
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
`ifdef REG_WRITE_ARB_ZERO_FILTER_EN
            // r0 reads as zero: the request is consumed but never written
            wr_vld_d  = (sel_addr != '0);
`else
            wr_vld_d  = 1'b1;
`endif
            if (gnt_idx == PTR_W'(N_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + PTR_W'(1);
            end
        end
    end

    // State registers; reset discards any accepted-but-not-issued write
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q     <= '0;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_vld_q  <= wr_vld_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Drive the register-file port and activity flag
    always_comb begin
        Write_Reg = wr_vld_q;
        Wr_Addr   = wr_addr_q;
        Wr_Data   = wr_data_q;
        Busy      = (|Req_Valid) || wr_vld_q;
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: reset, round-robin order, stall, wrap, zero address, async reset.
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
// Backpressure: requesters hold Valid/Addr/Data until their Ready was seen at an edge.
module tb_reg_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            CLK;
    logic            RST_N;
    logic [N-1:0]    Req_Valid;
    logic [N*AW-1:0] Req_Addr;
    logic [N*DW-1:0] Req_Data;
    logic [N-1:0]    Req_Ready;
    logic            Stall;
    logic [AW-1:0]   Wr_Addr;
    logic [DW-1:0]   Wr_Data;
    logic            Write_Reg;
    logic            Busy;

    int checks   = 0;
    int failures = 0;

    reg_write_arbiter #(
        .N_REQ  (N),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .Req_Valid (Req_Valid),
        .Req_Addr  (Req_Addr),
        .Req_Data  (Req_Data),
        .Req_Ready (Req_Ready),
        .Stall     (Stall),
        .Wr_Addr   (Wr_Addr),
        .Wr_Data   (Wr_Data),
        .Write_Reg (Write_Reg),
        .Busy      (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        Req_Addr[i*AW +: AW] = a;
        Req_Data[i*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N     = 1'b0;
        Stall     = 1'b0;
        Req_Valid = 3'b111;
        Req_Addr  = '0;
        Req_Data  = '0;
        set_req(0, 5'd1, 32'hA000_0001);
        set_req(1, 5'd2, 32'hA000_0002);
        set_req(2, 5'd3, 32'hA000_0003);

        // Reset held with all requesters valid
        #3;
        chk("rst_ready", 32'(Req_Ready), 32'h0);
        chk("rst_wreg",  32'(Write_Reg), 32'h0);
        chk("rst_addr",  32'(Wr_Addr),   32'h0);
        chk("rst_data",  Wr_Data,        32'h0);
        chk("rst_busy",  32'(Busy),      32'h1);

        // Release between edges: pointer starts at req0
        #9;
        RST_N = 1'b1;
        #1;
        chk("rel_ready", 32'(Req_Ready), 32'h1);

        // All three valid: writes 1,2,3,1,2,3 back to back
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_wreg",  32'(Write_Reg), 32'h1);
            chk("rr_addr",  32'(Wr_Addr),   32'(k % 3 + 1));
            chk("rr_data",  Wr_Data,        32'hA000_0000 + 32'(k % 3 + 1));
            chk("rr_ready", 32'(Req_Ready), 32'(1 << ((k + 1) % 3)));
        end

        // Stall with only req1 valid; write accepted last edge still issues
        Stall     = 1'b1;
        Req_Valid = 3'b010;
        #1;
        chk("stall_ready0", 32'(Req_Ready), 32'h0);
        chk("stall_infl",   32'(Write_Reg), 32'h1);
        chk("stall_infl_a", 32'(Wr_Addr),   32'h3);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("stall_wreg",  32'(Write_Reg), 32'h0);
            chk("stall_ready", 32'(Req_Ready), 32'h0);
            chk("stall_hold",  32'(Wr_Addr),   32'h3);
        end
        Stall = 1'b0;
        #1;
        chk("unstall_ready", 32'(Req_Ready), 32'h2);
        tick();
        chk("unstall_wreg", 32'(Write_Reg), 32'h1);
        chk("unstall_addr", 32'(Wr_Addr),   32'h2);

        // Wrap: ptr=2, only req0 valid
        Req_Valid = 3'b001;
        set_req(0, 5'd7, 32'hDEAD_BEEF);
        #1;
        chk("wrap_ready", 32'(Req_Ready), 32'h1);
        tick();
        chk("wrap_wreg", 32'(Write_Reg), 32'h1);
        chk("wrap_addr", 32'(Wr_Addr),   32'h7);
        chk("wrap_data", Wr_Data,        32'hDEAD_BEEF);
        Req_Valid = 3'b111;
        #1;
        chk("wrap_ptr1", 32'(Req_Ready), 32'h2);
        tick();
        chk("wrap_next_addr", 32'(Wr_Addr), 32'h2);

        // Single requester is served every cycle whatever the pointer
        Req_Valid = 3'b001;
        #1;
        chk("single_ready0", 32'(Req_Ready), 32'h1);
        for (int s = 0; s < 2; s++) begin
            tick();
            chk("single_wreg",  32'(Write_Reg), 32'h1);
            chk("single_addr",  32'(Wr_Addr),   32'h7);
            chk("single_ready", 32'(Req_Ready), 32'h1);
        end

        // Address 0 request
        set_req(0, 5'd0, 32'h0000_0055);
        #1;
        chk("zero_ready", 32'(Req_Ready), 32'h1);
        tick();
        Req_Valid = 3'b000;
        #1;
`ifdef REG_WRITE_ARB_ZERO_FILTER_EN
        chk("zero_wreg", 32'(Write_Reg), 32'h0);
        chk("zero_busy", 32'(Busy),      32'h0);
`else
        chk("zero_wreg", 32'(Write_Reg), 32'h1);
        chk("zero_addr", 32'(Wr_Addr),   32'h0);
        chk("zero_data", Wr_Data,        32'h0000_0055);
        chk("zero_busy", 32'(Busy),      32'h1);
`endif
        tick();
        chk("idle_wreg",  32'(Write_Reg), 32'h0);
        chk("idle_busy",  32'(Busy),      32'h0);
        chk("idle_ready", 32'(Req_Ready), 32'h0);

        // Async reset while an accepted write is on the port
        set_req(1, 5'd9, 32'h0000_0099);
        Req_Valid = 3'b010;
        #1;
        chk("ar_ready", 32'(Req_Ready), 32'h2);
        tick();
        chk("ar_issue", 32'(Write_Reg), 32'h1);
        chk("ar_addr9", 32'(Wr_Addr),   32'h9);
        Req_Valid = 3'b000;
        RST_N     = 1'b0;
        #1;
        chk("ar_wreg", 32'(Write_Reg), 32'h0);
        chk("ar_addr", 32'(Wr_Addr),   32'h0);
        chk("ar_data", Wr_Data,        32'h0);
        set_req(1, 5'd5, 32'h0000_0011);
        set_req(2, 5'd5, 32'h0000_0022);
        Req_Valid = 3'b110;
        #1;
        chk("ar_ready_rst", 32'(Req_Ready), 32'h0);
        #2;
        RST_N = 1'b1;
        #1;
        chk("ar_ptr_reset", 32'(Req_Ready), 32'h2);

        // Same address from two requesters: rr order, second write lands last
        tick();
        chk("same_wreg1",  32'(Write_Reg), 32'h1);
        chk("same_addr1",  32'(Wr_Addr),   32'h5);
        chk("same_data1",  Wr_Data,        32'h0000_0011);
        chk("same_ready2", 32'(Req_Ready), 32'h4);
        Req_Valid = 3'b100;
        tick();
        chk("same_addr2", 32'(Wr_Addr), 32'h5);
        chk("same_data2", Wr_Data,      32'h0000_0022);
        Req_Valid = 3'b000;
        tick();
        chk("end_wreg", 32'(Write_Reg), 32'h0);
        chk("end_busy", 32'(Busy),      32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound the run in case the sequence ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
